pkt_dispatch_queue: RTL

Parametrised packet dispatcher between the packet slot memory and the output ports of the router. For each completed packet slot it reads the dest_id byte, maps it to one of NUM_PORTS output ports and queues the slot index on that port. It presents the head slot of each queue to its port and collects per-port done pulses, which may arrive out of order. It returns slots to the writer strictly in order through a binary and a Gray read pointer.

---
 rtl/pkt_dispatch_queue.sv | 98 +++++++++
 1 files changed

// File: rtl/pkt_dispatch_queue.sv
// pkt_dispatch_queue: classify completed slots by dest_id into per-port queues and release them in order.
module pkt_dispatch_queue #(
  parameter int NUM_PORTS = 3,
  parameter int PTR_SZ    = 2,
  parameter int PTR_IN_SZ = 4,
  parameter int UWIDTH    = 8,
  parameter int DEST_LSB  = 4,
  parameter int SEL_SZ    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PTR_SZ:0]             rq2_wptr,
  output logic                        uread_en,
  output logic [PTR_SZ-1:0]           uaddr,
  output logic [PTR_IN_SZ-1:0]        uaddr_in,
  input  logic [UWIDTH-1:0]           udata,
  output logic [NUM_PORTS-1:0]        read_port_en,
  output logic [NUM_PORTS*PTR_SZ-1:0] raddr_port,
  input  logic [NUM_PORTS-1:0]        read_port_done,
  output logic [PTR_SZ:0]             rptr,
  output logic [PTR_SZ:0]             rptr_gray,
  output logic [7:0]                  drop_cnt
);
  localparam int SLOTS = 1 << PTR_SZ;
  typedef enum logic [1:0] {IDLE, FETCH, CLASSIFY} state_t;
  state_t state, state_nxt;
  logic [PTR_SZ:0] vrptr, rptr_nxt;
  logic [SLOTS-1:0] done, done_nxt;
  logic [PTR_SZ-1:0] q_mem [NUM_PORTS][SLOTS];
  logic [PTR_SZ:0] q_ridx [NUM_PORTS];
  logic [PTR_SZ:0] q_widx [NUM_PORTS];
  logic [PTR_SZ-1:0] head [NUM_PORTS];
  logic [NUM_PORTS-1:0] push, pop;
  logic [SEL_SZ-1:0] sel;
  logic classify, route_ok, drop, release_en;
  logic unused_ok;
  assign sel        = udata[DEST_LSB +: SEL_SZ];
  assign unused_ok  = ^udata;
  assign classify   = state == CLASSIFY;
  assign route_ok   = int'(sel) < NUM_PORTS;
  assign drop       = classify && !route_ok;
  assign release_en = (rptr != vrptr) && done[rptr[PTR_SZ-1:0]];
  assign rptr_nxt   = rptr + (PTR_SZ+1)'(release_en);
  assign uread_en   = state == FETCH;
  always_comb begin
    state_nxt = state == IDLE  ? (vrptr != rq2_wptr ? FETCH : IDLE) :
                state == FETCH ? CLASSIFY : IDLE;
  end
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign head[p]         = q_mem[p][q_ridx[p][PTR_SZ-1:0]];
    assign read_port_en[p] = q_ridx[p] != q_widx[p];
    assign raddr_port[p*PTR_SZ +: PTR_SZ] = read_port_en[p] ? head[p] : '0;
    assign push[p] = classify && route_ok && (int'(sel) == p);
    assign pop[p]  = read_port_done[p] && read_port_en[p];
  end
  // A bit being set is never the one being released, so set/clear order cannot collide.
  always_comb begin
    done_nxt = done;
    if (release_en) done_nxt[rptr[PTR_SZ-1:0]] = 1'b0;
    if (drop) done_nxt[vrptr[PTR_SZ-1:0]] = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++)
      if (pop[p]) done_nxt[head[p]] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vrptr     <= '0;
      done      <= '0;
      rptr      <= '0;
      rptr_gray <= '0;
      drop_cnt  <= '0;
      uaddr     <= '0;
      uaddr_in  <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        q_ridx[p] <= '0;
        q_widx[p] <= '0;
      end
    end else begin
      state     <= state_nxt;
      done      <= done_nxt;
      rptr      <= rptr_nxt;
      rptr_gray <= rptr_nxt ^ (rptr_nxt >> 1);
      if (state == IDLE && state_nxt == FETCH) begin
        uaddr    <= vrptr[PTR_SZ-1:0];
        uaddr_in <= PTR_IN_SZ'(1);
      end
      if (classify) vrptr <= vrptr + (PTR_SZ+1)'(1);
      if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (push[p]) begin
          q_mem[p][q_widx[p][PTR_SZ-1:0]] <= vrptr[PTR_SZ-1:0];
          q_widx[p] <= q_widx[p] + (PTR_SZ+1)'(1);
        end
        if (pop[p]) q_ridx[p] <= q_ridx[p] + (PTR_SZ+1)'(1);
      end
    end
  end
endmodule
